// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the two-requester register write arbiter:
// state encoding, default data width and a grant-vector helper.
package reg_write_arbiter_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic [1:0] oneHot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side bus of the write arbiter: requests and data in, grant,
// write-complete, register contents and busy status out.
interface reg_write_arbiter_if
   import reg_write_arbiter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) ();

   logic [1:0]       req;
   logic [WIDTH-1:0] din0;
   logic [WIDTH-1:0] din1;
   logic [1:0]       gnt;
   logic [1:0]       ack;
   logic [WIDTH-1:0] q;
   logic             busy;

   modport master (
      output req, din0, din1,
      input  gnt, ack, q, busy
   );

   modport slave (
      input  req, din0, din1,
      output gnt, ack, q, busy
   );

endinterface

// File: rtl/reg_write_arbiter_dff_en_clrn.sv
// WIDTH-bit D register with load enable and asynchronous active-low clear;
// holds the shared register contents.
module dff_en_clrn #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Two-requester arbiter for a single shared register: IDLE -> GRANT -> DONE,
// with ties broken in favour of the requester that was not served last.
module reg_write_arbiter
   import reg_write_arbiter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic                 clk,
   input  logic                 clrn,
   reg_write_arbiter_if.slave   bus
);

   state_t           r_state;
   logic             r_sel;
   logic             r_last;
   logic [1:0]       r_gnt;
   logic [1:0]       r_ack;
   logic             r_busy;

   logic             w_winner;
   logic             w_load;
   logic [WIDTH-1:0] w_d;

   // On a tie the requester not recorded in r_last wins.
   always_comb begin
      w_winner = (bus.req == 2'b11) ? ~r_last : bus.req[1];
      w_load   = (r_state == GRANT);
      w_d      = r_sel ? bus.din1 : bus.din0;
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_state <= IDLE;
         r_sel   <= 1'b0;
         r_last  <= 1'b1;
         r_gnt   <= 2'b00;
         r_ack   <= 2'b00;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_ack <= 2'b00;
               if (bus.req != 2'b00) begin
                  r_sel   <= w_winner;
                  r_gnt   <= oneHot(w_winner);
                  r_busy  <= 1'b1;
                  r_state <= GRANT;
               end else begin
                  r_gnt   <= 2'b00;
                  r_busy  <= 1'b0;
               end
            end
            GRANT: begin
               r_ack   <= oneHot(r_sel);
               r_gnt   <= 2'b00;
               r_last  <= r_sel;
               r_busy  <= 1'b1;
               r_state <= DONE;
            end
            DONE: begin
               r_ack   <= 2'b00;
               r_gnt   <= 2'b00;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_ack   <= 2'b00;
               r_gnt   <= 2'b00;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   // The register loads only on the GRANT->DONE edge, so a reset during
   // GRANT clears it before the write can land.
   dff_en_clrn #(.WIDTH(WIDTH)) u_qReg (
      .clk  (clk),
      .clrn (clrn),
      .en   (w_load),
      .d    (w_d),
      .q    (bus.q)
   );

   assign bus.gnt  = r_gnt;
   assign bus.ack  = r_ack;
   assign bus.busy = r_busy;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios with literal
// expectations plus a per-cycle comparison against a write-schedule model.
module tb_reg_write_arbiter;

   logic clk = 1'b0;
   logic clrn;

   always #5 clk = ~clk;

   reg_write_arbiter_if #(.WIDTH(8)) bus ();

   reg_write_arbiter #(.WIDTH(8)) dut (
      .clk  (clk),
      .clrn (clrn),
      .bus  (bus)
   );

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [7:0] q;
      logic [1:0] ack;
      int         edgeNo;
   } logEntry_t;

   logEntry_t writeLog[$];

   // Schedule model: a sample at edge N books the grant at N, the write at
   // N+1 and frees the arbiter to sample again at N+3.
   int         edgeCnt   = 0;
   int         grantEdge = -10;
   int         ackEdge   = -10;
   int         freeEdge  = 0;
   logic       win       = 1'b0;
   logic       last      = 1'b1;
   logic [7:0] expQ      = 8'h00;
   logic [1:0] expGnt    = 2'b00;
   logic [1:0] expAck    = 2'b00;
   logic       expBusy   = 1'b0;

   always @(posedge clk) begin
      edgeCnt = edgeCnt + 1;
      if (!clrn) begin
         grantEdge = -10;
         ackEdge   = -10;
         freeEdge  = 0;
         last      = 1'b1;
         expQ      = 8'h00;
      end else begin
         if (edgeCnt == ackEdge) begin
            expQ = win ? bus.din1 : bus.din0;
            last = win;
         end
         if (edgeCnt >= freeEdge && bus.req != 2'b00) begin
            win       = (bus.req == 2'b11) ? !last : bus.req[1];
            grantEdge = edgeCnt;
            ackEdge   = edgeCnt + 1;
            freeEdge  = edgeCnt + 3;
         end
      end
      expGnt  = (edgeCnt == grantEdge) ? (2'b01 << win) : 2'b00;
      expAck  = (edgeCnt == ackEdge)   ? (2'b01 << win) : 2'b00;
      expBusy = (edgeCnt == grantEdge) || (edgeCnt == ackEdge);
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      tests = tests + 1;
      if (act !== exp) begin
         fails = fails + 1;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      checkOutput("model gnt", {30'd0, bus.gnt}, {30'd0, expGnt});
      checkOutput("model ack", {30'd0, bus.ack}, {30'd0, expAck});
      checkOutput("model q", {24'd0, bus.q}, {24'd0, expQ});
      checkOutput("model busy", {31'd0, bus.busy}, {31'd0, expBusy});
      checkOutput("onehot exclusive",
                  {31'd0, ($onehot0(bus.gnt) && $onehot0(bus.ack) &&
                           !(bus.gnt != 2'b00 && bus.ack != 2'b00))},
                  32'd1);
      if (bus.ack != 2'b00) writeLog.push_back('{bus.q, bus.ack, edgeCnt});
   end

   task automatic applyStimulus(input logic [1:0] r, input logic [7:0] d0,
                                input logic [7:0] d1);
      @(negedge clk);
      bus.req  = r;
      bus.din0 = d0;
      bus.din1 = d1;
   endtask

   task automatic doReset();
      @(negedge clk);
      clrn    = 1'b0;
      bus.req = 2'b00;
      @(negedge clk);
      @(negedge clk);
      clrn = 1'b1;
   endtask

   task automatic waitAck();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.ack != 2'b00) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("ack within bound", {31'd0, ok}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: run exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      clrn     = 1'b0;
      bus.req  = 2'b00;
      bus.din0 = 8'h00;
      bus.din1 = 8'h00;

      // Reset state
      @(negedge clk);
      checkOutput("reset q", {24'd0, bus.q}, 32'h00);
      checkOutput("reset gnt", {30'd0, bus.gnt}, 32'd0);
      checkOutput("reset busy", {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      clrn = 1'b1;

      // Single requester 0
      applyStimulus(2'b01, 8'hA5, 8'h00);
      @(negedge clk);
      checkOutput("s1 gnt", {30'd0, bus.gnt}, 32'd1);
      @(negedge clk);
      checkOutput("s1 ack", {30'd0, bus.ack}, 32'd1);
      checkOutput("s1 q", {24'd0, bus.q}, 32'hA5);
      bus.req = 2'b00;
      @(negedge clk);
      checkOutput("s1 busy low", {31'd0, bus.busy}, 32'd0);

      // Both requesters held: alternate starting with requester 0
      doReset();
      writeLog.delete();
      applyStimulus(2'b11, 8'h11, 8'h22);
      repeat (8) @(negedge clk);
      bus.req = 2'b00;
      repeat (3) @(negedge clk);
      checkOutput("s2 writes", writeLog.size(), 32'd3);
      if (writeLog.size() == 3) begin
         checkOutput("s2 q0", {24'd0, writeLog[0].q}, 32'h11);
         checkOutput("s2 q1", {24'd0, writeLog[1].q}, 32'h22);
         checkOutput("s2 q2", {24'd0, writeLog[2].q}, 32'h11);
         checkOutput("s2 ack0", {30'd0, writeLog[0].ack}, 32'd1);
         checkOutput("s2 ack1", {30'd0, writeLog[1].ack}, 32'd2);
         checkOutput("s2 ack2", {30'd0, writeLog[2].ack}, 32'd1);
      end

      // Request dropped during GRANT still completes
      applyStimulus(2'b10, 8'h00, 8'h3C);
      @(negedge clk);
      checkOutput("s3 gnt", {30'd0, bus.gnt}, 32'd2);
      bus.req = 2'b00;
      @(negedge clk);
      checkOutput("s3 ack", {30'd0, bus.ack}, 32'd2);
      checkOutput("s3 q", {24'd0, bus.q}, 32'h3C);
      repeat (2) @(negedge clk);

      // Reset during GRANT aborts the write
      writeLog.delete();
      applyStimulus(2'b01, 8'hFF, 8'h00);
      @(negedge clk);
      checkOutput("s4 gnt", {30'd0, bus.gnt}, 32'd1);
      clrn    = 1'b0;
      bus.req = 2'b00;
      #1;
      checkOutput("s4 async q", {24'd0, bus.q}, 32'h00);
      checkOutput("s4 async gnt", {30'd0, bus.gnt}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("s4 ack", {30'd0, bus.ack}, 32'd0);
      checkOutput("s4 q", {24'd0, bus.q}, 32'h00);
      checkOutput("s4 no write", writeLog.size(), 32'd0);
      clrn = 1'b1;
      applyStimulus(2'b01, 8'h5A, 8'h00);
      @(negedge clk);
      checkOutput("s4 regnt", {30'd0, bus.gnt}, 32'd1);
      @(negedge clk);
      checkOutput("s4 reack", {30'd0, bus.ack}, 32'd1);
      checkOutput("s4 req", {24'd0, bus.q}, 32'h5A);
      bus.req = 2'b00;
      repeat (2) @(negedge clk);

      // Requester 0 held: one write every 3 cycles, din0 changed on ack
      writeLog.delete();
      applyStimulus(2'b01, 8'h10, 8'h00);
      for (int k = 0; k < 4; k++) begin
         waitAck();
         bus.din0 = 8'(8'h20 + 8'(k) * 8'h10);
      end
      bus.req = 2'b00;
      repeat (3) @(negedge clk);
      checkOutput("s5 writes", writeLog.size(), 32'd4);
      if (writeLog.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            checkOutput("s5 q", {24'd0, writeLog[k].q}, 32'h10 * (k + 1));
            checkOutput("s5 ack", {30'd0, writeLog[k].ack}, 32'd1);
            if (k > 0)
               checkOutput("s5 spacing",
                           writeLog[k].edgeNo - writeLog[k-1].edgeNo, 32'd3);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
